// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line; hit answers 1 cycle after the request, miss after memctrl latency + 1.
// rdy_in=0 freezes state, arrays and outputs; clear aborts any fetch at once. ICACHE_PERF_EN adds hit/miss counters.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_enable,
   input  logic [31:0] if_addr,
   output logic        inst_ready,
   output logic [31:0] inst,
   output logic        mc_if_enable,
   output logic [31:0] mc_inst_addr,
   input  logic        mc_if_ready,
   input  logic [31:0] mc_inst
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

   state_t                state_q, state_d;
   logic                  inst_ready_q, inst_ready_d;
   logic [31:0]           inst_q, inst_d;
   logic                  mc_en_q, mc_en_d;
   logic [31:0]           mc_addr_q, mc_addr_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES];

   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  lookup_hit, fill_we;

   assign req_idx    = if_addr[INDEX_BITS+1:2];
   assign req_tag    = if_addr[31:INDEX_BITS+2];
   assign fill_idx   = mc_addr_q[INDEX_BITS+1:2];
   assign fill_tag   = mc_addr_q[31:INDEX_BITS+2];
   assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d      = state_q;
      inst_ready_d = inst_ready_q;
      inst_d       = inst_q;
      mc_en_d      = mc_en_q;
      mc_addr_d    = mc_addr_q;
      valid_d      = valid_q;
      fill_we      = 1'b0;
      if (clear) begin
         state_d      = IDLE;
         inst_ready_d = 1'b0;
         mc_en_d      = 1'b0;
      end else if (rdy_in) begin
         case (state_q)
            IDLE: begin
               if (if_enable) begin
                  mc_addr_d = if_addr & 32'hFFFF_FFFC;
                  if (lookup_hit) begin
                     inst_d       = data_q[req_idx];
                     inst_ready_d = 1'b1;
                     state_d      = RESP;
                  end else begin
                     mc_en_d = 1'b1;
                     state_d = MISS;
                  end
               end
            end
            MISS: begin
               // if_enable is deliberately ignored here: a started fill always completes
               if (mc_if_ready) begin
                  fill_we           = 1'b1;
                  valid_d[fill_idx] = 1'b1;
                  inst_d            = mc_inst;
                  inst_ready_d      = 1'b1;
                  mc_en_d           = 1'b0;
                  state_d           = RESP;
               end
            end
            RESP: begin
               inst_ready_d = 1'b0;
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         inst_ready_q <= 1'b0;
         inst_q       <= '0;
         mc_en_q      <= 1'b0;
         mc_addr_q    <= '0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         inst_ready_q <= inst_ready_d;
         inst_q       <= inst_d;
         mc_en_q      <= mc_en_d;
         mc_addr_q    <= mc_addr_d;
         valid_q      <= valid_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mc_inst;
      end
   end

   // clear must silence the handshakes in the very cycle it is raised
   assign inst_ready   = inst_ready_q & ~clear;
   assign mc_if_enable = mc_en_q & ~clear;
   assign inst         = inst_q;
   assign mc_inst_addr = mc_addr_q;

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic        lookup_evt;

   assign lookup_evt = (state_q == IDLE) && rdy_in && !clear && if_enable;

   always_comb begin
      hit_cnt_d  = hit_cnt_q + {31'd0, lookup_evt && lookup_hit};
      miss_cnt_d = miss_cnt_q + {31'd0, lookup_evt && !lookup_hit};
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule
